// File: rtl/freg_pkg.sv
// Shared types and constants for the FP register file and its scoreboard.
// No logic here. Latency and backpressure do not apply.
// These defaults set the F-extension sizes that the other files pick up.
package freg_pkg;
  localparam int FREG_DATA_WIDTH = 32;
  localparam int FREG_ADDR_WIDTH = 5;
  localparam int NUM_REGS        = 2**FREG_ADDR_WIDTH;

  // Write port indices: FPU writeback has priority over loads.
  localparam int WR_FPU  = 0;
  localparam int WR_LOAD = 1;

  typedef logic [FREG_ADDR_WIDTH-1:0] freg_addr_t;
  typedef logic [FREG_DATA_WIDTH-1:0] freg_data_t;
endpackage

// File: rtl/freg_scoreboard.sv
// Busy-bit scoreboard: tracks pending FP writes and gates issue on RAW/WAW hazards.
// issue_ready_o is combinational from the current busy state. Busy updates take effect at the next edge.
// Backpressure: ready drops on a hazard and does not depend on issue_valid_i. FREG_BYPASS_EN lets same-cycle writes resolve RAW.
module freg_scoreboard
  import freg_pkg::*;
#(
  parameter int ADDR_WIDTH = FREG_ADDR_WIDTH,
  parameter int NUM_RD     = 3
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rs_addr_i,
  input  logic [NUM_RD-1:0]            issue_rs_use_i,
  input  logic                         issue_valid_i,
  input  logic                         issue_rd_we_i,
  input  logic [ADDR_WIDTH-1:0]        issue_rd_i,
  input  logic [1:0]                   wr_en_i,
  input  logic [2*ADDR_WIDTH-1:0]      wr_addr_i,
  output logic [2**ADDR_WIDTH-1:0]     busy_o,
  output logic                         issue_ready_o
);
  localparam int NREGS = 2**ADDR_WIDTH;

  logic [NREGS-1:0]      busy_q;
  logic [NREGS-1:0]      busy_d;
  logic                  raw_hit;
  logic                  waw_hit;
  logic [ADDR_WIDTH-1:0] src_addr;

  // True when either write port targets address a this cycle.
  function automatic logic wr_hits(input logic [1:0] en,
                                   input logic [2*ADDR_WIDTH-1:0] wa,
                                   input logic [ADDR_WIDTH-1:0] a);
    return (en[WR_FPU]  && (wa[WR_FPU*ADDR_WIDTH +: ADDR_WIDTH]  == a)) ||
           (en[WR_LOAD] && (wa[WR_LOAD*ADDR_WIDTH +: ADDR_WIDTH] == a));
  endfunction

  // Hazard detection. A write landing on the destination always clears WAW.
  always_comb begin
    raw_hit  = 1'b0;
    waw_hit  = 1'b0;
    src_addr = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      src_addr = rs_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
`ifdef FREG_BYPASS_EN
      if (issue_rs_use_i[k] && busy_q[src_addr] && !wr_hits(wr_en_i, wr_addr_i, src_addr))
        raw_hit = 1'b1;
`else
      if (issue_rs_use_i[k] && busy_q[src_addr])
        raw_hit = 1'b1;
`endif
    end
    if (issue_rd_we_i && busy_q[issue_rd_i] && !wr_hits(wr_en_i, wr_addr_i, issue_rd_i))
      waw_hit = 1'b1;
    issue_ready_o = !raw_hit && !waw_hit;
  end

  // Next busy state: writes clear first, then an accepted issue sets, so set wins.
  always_comb begin
    busy_d = busy_q;
    for (int p = 0; p < 2; p++) begin
      if (wr_en_i[p])
        busy_d[wr_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
    end
    if (issue_valid_i && issue_ready_o && issue_rd_we_i)
      busy_d[issue_rd_i] = 1'b1;
  end

  // Busy register. Reset drops every pending entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) busy_q <= '0;
    else         busy_q <= busy_d;
  end

  assign busy_o = busy_q;
endmodule

// File: rtl/freg_sb.sv
// FP register file (NUM_RD comb read ports, FPU + load write ports) with integrated issue scoreboard.
// Reads take 0 cycles and writes take 1. With FREG_BYPASS_EN, write data is forwarded to reads in the same cycle.
// Backpressure: issue_ready_o stalls issue on RAW/WAW. Write ports are never stalled.
module freg_sb
  import freg_pkg::*;
#(
  parameter int DATA_WIDTH = FREG_DATA_WIDTH,
  parameter int ADDR_WIDTH = FREG_ADDR_WIDTH,
  parameter int NUM_RD     = 3
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rs_addr_i,
  output logic [NUM_RD*DATA_WIDTH-1:0] rs_data_o,
  output logic [NUM_RD-1:0]            rs_busy_o,
  input  logic                         issue_valid_i,
  input  logic [NUM_RD-1:0]            issue_rs_use_i,
  input  logic                         issue_rd_we_i,
  input  logic [ADDR_WIDTH-1:0]        issue_rd_i,
  output logic                         issue_ready_o,
  input  logic [1:0]                   wr_en_i,
  input  logic [2*ADDR_WIDTH-1:0]      wr_addr_i,
  input  logic [2*DATA_WIDTH-1:0]      wr_data_i
);
  localparam int NREGS = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [NREGS];
  logic [NREGS-1:0]      busy;
  logic [ADDR_WIDTH-1:0] rd_addr;

  freg_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_RD     (NUM_RD)
  ) u_scoreboard (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .rs_addr_i      (rs_addr_i),
    .issue_rs_use_i (issue_rs_use_i),
    .issue_valid_i  (issue_valid_i),
    .issue_rd_we_i  (issue_rd_we_i),
    .issue_rd_i     (issue_rd_i),
    .wr_en_i        (wr_en_i),
    .wr_addr_i      (wr_addr_i),
    .busy_o         (busy),
    .issue_ready_o  (issue_ready_o)
  );

  // Storage. The load port is applied first so that an FPU write to the same address overrides it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else begin
      if (wr_en_i[WR_LOAD])
        mem[wr_addr_i[WR_LOAD*ADDR_WIDTH +: ADDR_WIDTH]] <= wr_data_i[WR_LOAD*DATA_WIDTH +: DATA_WIDTH];
      if (wr_en_i[WR_FPU])
        mem[wr_addr_i[WR_FPU*ADDR_WIDTH +: ADDR_WIDTH]] <= wr_data_i[WR_FPU*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Read muxes. With bypass, a matching write forwards its data and masks busy, and the FPU port is checked last so it wins.
  always_comb begin
    rs_data_o = '0;
    rs_busy_o = '0;
    rd_addr   = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_addr = rs_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
      rs_data_o[k*DATA_WIDTH +: DATA_WIDTH] = mem[rd_addr];
      rs_busy_o[k] = busy[rd_addr];
`ifdef FREG_BYPASS_EN
      if (wr_en_i[WR_LOAD] && (wr_addr_i[WR_LOAD*ADDR_WIDTH +: ADDR_WIDTH] == rd_addr)) begin
        rs_data_o[k*DATA_WIDTH +: DATA_WIDTH] = wr_data_i[WR_LOAD*DATA_WIDTH +: DATA_WIDTH];
        rs_busy_o[k] = 1'b0;
      end
      if (wr_en_i[WR_FPU] && (wr_addr_i[WR_FPU*ADDR_WIDTH +: ADDR_WIDTH] == rd_addr)) begin
        rs_data_o[k*DATA_WIDTH +: DATA_WIDTH] = wr_data_i[WR_FPU*DATA_WIDTH +: DATA_WIDTH];
        rs_busy_o[k] = 1'b0;
      end
`endif
    end
  end
endmodule

// File: tb/tb_freg_sb.sv
module tb_freg_sb;
  import freg_pkg::*;

`ifdef FREG_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk_i;
  logic          rst_ni;
  logic [14:0]   rs_addr_i;
  logic [95:0]   rs_data_o;
  logic [2:0]    rs_busy_o;
  logic          issue_valid_i;
  logic [2:0]    issue_rs_use_i;
  logic          issue_rd_we_i;
  logic [4:0]    issue_rd_i;
  logic          issue_ready_o;
  logic [1:0]    wr_en_i;
  logic [9:0]    wr_addr_i;
  logic [63:0]   wr_data_i;

  freg_sb dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .rs_addr_i      (rs_addr_i),
    .rs_data_o      (rs_data_o),
    .rs_busy_o      (rs_busy_o),
    .issue_valid_i  (issue_valid_i),
    .issue_rs_use_i (issue_rs_use_i),
    .issue_rd_we_i  (issue_rd_we_i),
    .issue_rd_i     (issue_rd_i),
    .issue_ready_o  (issue_ready_o),
    .wr_en_i        (wr_en_i),
    .wr_addr_i      (wr_addr_i),
    .wr_data_i      (wr_data_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    freg_addr_t ra0, ra1, ra2;
    logic [2:0] use_m;
    logic       iv, we;
    freg_addr_t rd;
    logic [1:0] wen;
    freg_addr_t wa0, wa1;
    freg_data_t wd0, wd1;
    freg_data_t e_d0;
    logic       e_b0;
    freg_data_t e_d1;
    logic       e_rdy;
  } vec_t;

  localparam int NV = 16;
  vec_t vt [NV];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rs_addr_i = '0; issue_valid_i = 0; issue_rs_use_i = '0; issue_rd_we_i = 0;
    issue_rd_i = '0; wr_en_i = '0; wr_addr_i = '0; wr_data_i = '0;
  endtask

  initial begin
    // Field order: ra0 ra1 ra2 use iv we rd wen wa0 wa1 wd0 wd1 | e_d0 e_b0 e_d1 e_rdy
    vt[0]  = '{0,0,0, 3'b000,0,0,0, 2'b01,0,0, 32'h3F80_0000,0,
               BYP ? 32'h3F80_0000 : 32'h0, 0, BYP ? 32'h3F80_0000 : 32'h0, 1};
    vt[1]  = '{0,0,0, 3'b000,0,0,0, 2'b00,0,0, 0,0, 32'h3F80_0000,0,32'h3F80_0000,1};
    vt[2]  = '{5,0,0, 3'b000,1,1,5, 2'b00,0,0, 0,0, 32'h0,0,32'h3F80_0000,1};
    vt[3]  = '{5,0,0, 3'b001,1,0,0, 2'b00,0,0, 0,0, 32'h0,1,32'h3F80_0000,0};
    vt[4]  = '{5,0,0, 3'b001,1,0,0, 2'b01,5,0, 32'h4000_0000,0,
               BYP ? 32'h4000_0000 : 32'h0, !BYP, 32'h3F80_0000, BYP};
    vt[5]  = '{5,0,0, 3'b001,1,0,0, 2'b00,0,0, 0,0, 32'h4000_0000,0,32'h3F80_0000,1};
    vt[6]  = '{7,7,0, 3'b000,0,0,0, 2'b11,7,7, 32'hA5A5_A5A5,32'h1234_5678,
               BYP ? 32'hA5A5_A5A5 : 32'h0, 0, BYP ? 32'hA5A5_A5A5 : 32'h0, 1};
    vt[7]  = '{7,0,0, 3'b000,0,0,0, 2'b00,0,0, 0,0, 32'hA5A5_A5A5,0,32'h3F80_0000,1};
    vt[8]  = '{9,0,0, 3'b000,1,1,9, 2'b00,0,0, 0,0, 32'h0,0,32'h3F80_0000,1};
    vt[9]  = '{9,0,0, 3'b000,1,1,9, 2'b00,0,0, 0,0, 32'h0,1,32'h3F80_0000,0};
    vt[10] = '{9,0,0, 3'b000,1,1,9, 2'b10,0,9, 0,32'h1111_1111,
               BYP ? 32'h1111_1111 : 32'h0, !BYP, 32'h3F80_0000, 1};
    vt[11] = '{9,12,0, 3'b000,0,0,0, 2'b10,0,12, 0,32'hCAFE_BABE,
               32'h1111_1111, 1, BYP ? 32'hCAFE_BABE : 32'h0, 1};
    vt[12] = '{12,12,0, 3'b000,1,1,3, 2'b00,0,0, 0,0, 32'hCAFE_BABE,0,32'hCAFE_BABE,1};
    vt[13] = '{3,0,9, 3'b110,1,0,0, 2'b00,0,0, 0,0, 32'h0,1,32'h3F80_0000,0};
    vt[14] = '{7,3,9, 3'b001,0,1,14, 2'b00,0,0, 0,0, 32'hA5A5_A5A5,0,32'h0,1};
    vt[15] = '{14,5,0, 3'b000,0,0,0, 2'b00,0,0, 0,0, 32'h0,0,32'h4000_0000,1};

    // Reset state: every register reads 0 and not busy on every port.
    idle_inputs();
    rst_ni = 1'b0;
    #1;
    for (int r = 0; r < 32; r++) begin
      rs_addr_i = {r[4:0], r[4:0], r[4:0]};
      issue_rs_use_i = 3'b111;
      #1;
      chk($sformatf("rst_data_f%0d", r), {32'h0, rs_data_o[31:0] | rs_data_o[63:32] | rs_data_o[95:64]}, 64'h0);
      chk($sformatf("rst_busy_f%0d", r), {61'h0, rs_busy_o}, 64'h0);
      chk($sformatf("rst_ready_f%0d", r), {63'h0, issue_ready_o}, 64'h1);
    end
    idle_inputs();
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Directed vector table, one cycle per row, checked before the edge that commits it.
    for (int i = 0; i < NV; i++) begin
      @(posedge clk_i);
      #1;
      rs_addr_i      = {vt[i].ra2, vt[i].ra1, vt[i].ra0};
      issue_rs_use_i = vt[i].use_m;
      issue_valid_i  = vt[i].iv;
      issue_rd_we_i  = vt[i].we;
      issue_rd_i     = vt[i].rd;
      wr_en_i        = vt[i].wen;
      wr_addr_i      = {vt[i].wa1, vt[i].wa0};
      wr_data_i      = {vt[i].wd1, vt[i].wd0};
      #2;
      chk($sformatf("v%0d_d0", i),  {32'h0, rs_data_o[31:0]},  {32'h0, vt[i].e_d0});
      chk($sformatf("v%0d_b0", i),  {63'h0, rs_busy_o[0]},     {63'h0, vt[i].e_b0});
      chk($sformatf("v%0d_d1", i),  {32'h0, rs_data_o[63:32]}, {32'h0, vt[i].e_d1});
      chk($sformatf("v%0d_rdy", i), {63'h0, issue_ready_o},    {63'h0, vt[i].e_rdy});
    end

    // Mid-stream reset with f3 and f9 busy and f7/f9 holding data.
    @(posedge clk_i);
    #1;
    idle_inputs();
    rs_addr_i      = {5'd7, 5'd9, 5'd3};
    issue_rs_use_i = 3'b111;
    issue_rd_we_i  = 1'b1;
    issue_rd_i     = 5'd9;
    #1;
    chk("pre_rst_busy", {61'h0, rs_busy_o}, {61'h0, 3'b011});
    chk("pre_rst_ready", {63'h0, issue_ready_o}, 64'h0);
    chk("pre_rst_f7", {32'h0, rs_data_o[95:64]}, {32'h0, 32'hA5A5_A5A5});
    #1;
    rst_ni = 1'b0;
    #1;
    chk("rst_busy", {61'h0, rs_busy_o}, 64'h0);
    chk("rst_ready", {63'h0, issue_ready_o}, 64'h1);
    chk("rst_data", {32'h0, rs_data_o[31:0] | rs_data_o[63:32] | rs_data_o[95:64]}, 64'h0);
    @(posedge clk_i);
    #2;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #2;
    chk("post_rst_busy", {61'h0, rs_busy_o}, 64'h0);
    chk("post_rst_ready", {63'h0, issue_ready_o}, 64'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
